// File: rtl/CPU_package.sv
`timescale 1ns/1ps
// CPU_package: shared CPU word width and ALU opcode encoding
package CPU_package;
   localparam int CPU_DATA_WIDTH = 16;
   typedef enum logic [3:0] {
      ALU_ADD = 4'h0,
      ALU_SUB = 4'h1,
      ALU_INC = 4'h2,
      ALU_DEC = 4'h3,
      ALU_SHL = 4'h4,
      ALU_SHR = 4'h5,
      ALU_MUL = 4'h6,
      ALU_DIV = 4'h7
   } enum_alu_opcode_t;
endpackage

// File: rtl/arith_unit_mc.sv
`timescale 1ns/1ps
// arith_unit_mc: multi-cycle arithmetic unit with iterative MUL/DIV and valid/ready handshakes
// Ports: in_valid/in_ready + alu_opcode/in_a/in_b/input_carry in; out_valid/out_ready +
// arith_out (low word/quotient), arith_out_hi (MUL high/DIV remainder), arith_out_flag {div0,ovf,zero,carry}.
module arith_unit_mc
   import CPU_package::*;
#(
   parameter int DATA_WIDTH = CPU_DATA_WIDTH,
   localparam int CNT_W = $clog2(DATA_WIDTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  enum_alu_opcode_t      alu_opcode,
   input  logic [DATA_WIDTH-1:0] in_a,
   input  logic [DATA_WIDTH-1:0] in_b,
   input  logic                  input_carry,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] arith_out,
   output logic [DATA_WIDTH-1:0] arith_out_hi,
   output logic [3:0]            arith_out_flag
);
   localparam int W = DATA_WIDTH;
   typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, DONE} state_t;
   state_t state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [W-1:0] a_q, a_d, b_q, b_d, acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
   logic [W-1:0] res_lo_q, res_lo_d, res_hi_q, res_hi_d, step_hi, step_lo, sc_lo, sc_hi;
   logic [3:0] flag_q, flag_d;
   logic [W:0] add_s, sub_s, mul_s, div_t;
   logic accept, busy, sc_carry, sc_ovf, sc_div0;
   assign busy = state_q == MUL_RUN || state_q == DIV_RUN;
   assign accept = in_valid && in_ready;
   assign add_s = {1'b0, in_a} + {1'b0, in_b} + (W+1)'(input_carry);
   assign sub_s = {1'b0, in_a} - {1'b0, in_b} - (W+1)'(input_carry);
   // MUL: {acc_hi,acc_lo} holds partial product and remaining multiplier bits, shifted right each step
   assign mul_s = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? a_q : {W{1'b0}})};
   // DIV: acc_hi is the running remainder, acc_lo shifts dividend bits out and quotient bits in
   assign div_t = {acc_hi_q, acc_lo_q[W-1]} - {1'b0, b_q};
   assign step_hi = state_q == MUL_RUN ? mul_s[W:1] : (div_t[W] ? {acc_hi_q[W-2:0], acc_lo_q[W-1]} : div_t[W-1:0]);
   assign step_lo = state_q == MUL_RUN ? {mul_s[0], acc_lo_q[W-1:1]} : {acc_lo_q[W-2:0], ~div_t[W]};
   always_comb begin
      sc_lo = '0;
      sc_hi = '0;
      sc_carry = 1'b0;
      sc_ovf = 1'b0;
      sc_div0 = 1'b0;
      case (alu_opcode)
         ALU_ADD: begin
            {sc_carry, sc_lo} = add_s;
            sc_ovf = (in_a[W-1] == in_b[W-1]) && (add_s[W-1] != in_a[W-1]);
         end
         ALU_SUB: begin
            {sc_carry, sc_lo} = sub_s;
            sc_ovf = (in_a[W-1] != in_b[W-1]) && (sub_s[W-1] != in_a[W-1]);
         end
         ALU_INC: begin
            sc_lo = in_a + W'(1);
            sc_carry = &in_a;
            sc_ovf = in_a == {1'b0, {(W-1){1'b1}}};
         end
         ALU_DEC: begin
            sc_lo = in_a - W'(1);
            sc_carry = ~|in_a;
            sc_ovf = in_a == {1'b1, {(W-1){1'b0}}};
         end
         ALU_SHL: {sc_carry, sc_lo} = {in_a, input_carry};
         ALU_SHR: {sc_lo, sc_carry} = {input_carry, in_a};
         // only reached with a zero divisor; non-zero divisors take the iterative path
         ALU_DIV: begin
            sc_lo = '1;
            sc_hi = in_a;
            sc_div0 = 1'b1;
         end
         default: ;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q <= '0;
         a_q <= '0;
         b_q <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         res_lo_q <= '0;
         res_hi_q <= '0;
         flag_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         a_q <= a_d;
         b_q <= b_d;
         acc_hi_q <= acc_hi_d;
         acc_lo_q <= acc_lo_d;
         res_lo_q <= res_lo_d;
         res_hi_q <= res_hi_d;
         flag_q <= flag_d;
      end
   end
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      a_d = a_q;
      b_d = b_q;
      acc_hi_d = acc_hi_q;
      acc_lo_d = acc_lo_q;
      res_lo_d = res_lo_q;
      res_hi_d = res_hi_q;
      flag_d = flag_q;
      if (busy) begin
         acc_hi_d = step_hi;
         acc_lo_d = step_lo;
         cnt_d = cnt_q - CNT_W'(1);
         if (cnt_q == CNT_W'(1)) begin
            state_d = DONE;
            res_lo_d = step_lo;
            res_hi_d = step_hi;
            flag_d = state_q == MUL_RUN ? {2'b00, ~|{step_hi, step_lo}, |step_hi} : {2'b00, ~|step_lo, 1'b0};
         end
      end else if (accept) begin
         a_d = in_a;
         b_d = in_b;
         if (alu_opcode == ALU_MUL || (alu_opcode == ALU_DIV && |in_b)) begin
            state_d = alu_opcode == ALU_MUL ? MUL_RUN : DIV_RUN;
            cnt_d = CNT_W'(W);
            acc_hi_d = '0;
            acc_lo_d = alu_opcode == ALU_MUL ? in_b : in_a;
         end else begin
            state_d = DONE;
            res_lo_d = sc_lo;
            res_hi_d = sc_hi;
            flag_d = {sc_div0, sc_ovf, ~|sc_lo, sc_carry};
         end
      end else if (state_q == DONE && out_ready) begin
         state_d = IDLE;
      end
   end
   always_comb begin
      out_valid = state_q == DONE;
      in_ready = rst_n && (state_q == IDLE || (state_q == DONE && out_ready));
      arith_out = res_lo_q;
      arith_out_hi = res_hi_q;
      arith_out_flag = flag_q;
   end
endmodule

// File: tb/tb_arith_unit_mc.sv
`timescale 1ns/1ps
// tb_arith_unit_mc: scoreboard bench with directed corners and randomized traffic for arith_unit_mc
module tb_arith_unit_mc;
   import CPU_package::*;
   localparam int W = 16;
   typedef struct {
      logic [W-1:0] lo;
      logic [W-1:0] hi;
      logic [3:0]   fl;
      int           lat;
      int           acc;
   } exp_t;
   logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_ready, input_carry = 1'b0, out_valid, out_ready = 1'b1;
   enum_alu_opcode_t alu_opcode = ALU_ADD;
   logic [W-1:0] in_a = '0, in_b = '0, arith_out, arith_out_hi;
   logic [3:0] arith_out_flag;
   int total = 0, bad = 0, cyc = 0;
   exp_t sb[$];
   exp_t cur;
   bit hold = 1'b0, rand_done = 1'b0;
   arith_unit_mc #(.DATA_WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .alu_opcode(alu_opcode),
      .in_a(in_a), .in_b(in_b), .input_carry(input_carry), .out_valid(out_valid), .out_ready(out_ready),
      .arith_out(arith_out), .arith_out_hi(arith_out_hi), .arith_out_flag(arith_out_flag)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", n, act, exp, cyc);
      end
   endtask
   function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
      exp_t e;
      longint full = longint'(1) << W;
      longint smax = (longint'(1) << (W - 1)) - 1;
      longint smin = -(longint'(1) << (W - 1));
      longint ua = a, ub = b, sa = $signed(a), sbv = $signed(b), r = 0, s = 0;
      logic c = 1'b0, v = 1'b0, d = 1'b0, z;
      e.hi = '0;
      e.lat = 1;
      e.acc = 0;
      case (op)
         ALU_ADD: begin r = ua + ub + cin; c = r >= full; s = sa + sbv + cin; v = s > smax || s < smin; end
         ALU_SUB: begin r = ua - ub - cin; c = ua < ub + cin; s = sa - sbv - cin; v = s > smax || s < smin; end
         ALU_INC: begin r = ua + 1; c = ua == full - 1; s = sa + 1; v = s > smax; end
         ALU_DEC: begin r = ua - 1; c = ua == 0; s = sa - 1; v = s < smin; end
         ALU_SHL: begin r = ua * 2 + cin; c = ua >= full / 2; end
         ALU_SHR: begin r = ua / 2 + cin * (full / 2); c = (ua % 2) == 1; end
         ALU_MUL: begin r = ua * ub; e.hi = W'(r / full); c = e.hi != 0; e.lat = W + 1; end
         ALU_DIV: begin
            if (ub == 0) begin r = full - 1; e.hi = a; d = 1'b1; end
            else begin r = ua / ub; e.hi = W'(ua % ub); e.lat = W + 1; end
         end
         default: r = 0;
      endcase
      e.lo = r[W-1:0];
      z = op == ALU_MUL ? r == 0 : e.lo == 0;
      e.fl = {d, v, z, c};
      return e;
   endfunction
   task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
      exp_t e;
      int n = 0;
      alu_opcode = enum_alu_opcode_t'(op);
      in_a = a;
      in_b = b;
      input_carry = cin;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 300) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) begin
         chk("accept_timeout", in_ready, 1);
         in_valid = 1'b0;
         return;
      end
      e = model(op, a, b, cin);
      e.acc = cyc + 1;
      sb.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_a = W'($urandom);
      in_b = W'($urandom);
      input_carry = 1'($urandom);
   endtask
   task automatic wait_drain();
      int n = 0;
      while ((sb.size() != 0 || hold) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", sb.size(), 0);
      @(posedge clk);
      #1;
   endtask
   function automatic logic [W-1:0] rnd_op();
      case ($urandom_range(0, 7))
         0: return '0;
         1: return '1;
         2: return 16'h7FFF;
         3: return 16'h8000;
         4: return 16'h0001;
         default: return W'($urandom);
      endcase
   endfunction
   always @(negedge clk) begin
      if (!rst_n) hold = 1'b0;
      else if (out_valid) begin
         if (!hold) begin
            if (sb.size() == 0) chk("unexpected_result", out_valid, 0);
            else begin
               cur = sb.pop_front();
               hold = 1'b1;
               chk("latency", cyc - cur.acc + 1, cur.lat);
            end
         end
         if (hold) begin
            chk("arith_out", arith_out, cur.lo);
            chk("arith_out_hi", arith_out_hi, cur.hi);
            chk("flags", arith_out_flag, cur.fl);
         end
         if (!out_ready) chk("in_ready_while_held", in_ready, 0);
         else hold = 1'b0;
      end else if (sb.size() > 0 && sb[0].lat > 1 && cyc >= sb[0].acc) begin
         chk("in_ready_while_busy", in_ready, 0);
      end
   end
   initial begin
      #2;
      chk("reset_out_valid", out_valid, 0);
      chk("reset_in_ready", in_ready, 0);
      chk("reset_arith_out", arith_out, 0);
      chk("reset_arith_out_hi", arith_out_hi, 0);
      chk("reset_flags", arith_out_flag, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      issue(ALU_ADD, 16'hFFFF, 16'h0001, 1'b0);
      issue(ALU_ADD, 16'h7FFF, 16'h0001, 1'b0);
      issue(ALU_SUB, 16'h0003, 16'h0005, 1'b1);
      issue(ALU_SHL, 16'h8001, 16'h0000, 1'b1);
      issue(ALU_SHR, 16'h0001, 16'h0000, 1'b1);
      issue(ALU_MUL, 16'hFFFF, 16'hFFFF, 1'b0);
      issue(ALU_DIV, 16'd1000, 16'd7, 1'b0);
      issue(ALU_DIV, 16'h1234, 16'h0000, 1'b0);
      issue(4'hC, 16'h5555, 16'hAAAA, 1'b1);
      issue(ALU_INC, 16'h7FFF, 16'h0000, 1'b0);
      issue(ALU_DEC, 16'h8000, 16'h0000, 1'b0);
      wait_drain();
      out_ready = 1'b0;
      issue(ALU_INC, 16'h00FF, 16'h0000, 1'b0);
      fork
         issue(ALU_DEC, 16'h0000, 16'h0000, 1'b0);
         begin
            repeat (5) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      wait_drain();
      issue(ALU_MUL, 16'hABCD, 16'h1234, 1'b0);
      repeat (7) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      sb.delete();
      chk("abort_out_valid", out_valid, 0);
      chk("abort_in_ready", in_ready, 0);
      chk("abort_arith_out", arith_out, 0);
      chk("abort_arith_out_hi", arith_out_hi, 0);
      chk("abort_flags", arith_out_flag, 0);
      @(negedge clk);
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      issue(ALU_ADD, 16'h1111, 16'h2222, 1'b1);
      wait_drain();
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               int k = $urandom_range(0, 9);
               logic [3:0] op = k < 8 ? 4'(k) : 4'($urandom_range(8, 15));
               if ($urandom_range(0, 4) == 0) begin
                  @(posedge clk);
                  #1;
               end
               issue(op, rnd_op(), rnd_op(), 1'($urandom));
            end
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk);
               #1 out_ready = $urandom_range(0, 3) != 0;
            end
            out_ready = 1'b1;
         end
      join
      wait_drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
